// File: rtl/dm_pkg.sv
// ============================================================================
// dm_pkg : shared types and constants for the 16-bit data-memory initiator
// Revision: 1.0
// ============================================================================
`default_nettype none

package dm_pkg;

    localparam int DM_ADDR_W = 24;
    localparam int DM_BEAT_W = 16;

    localparam logic [1:0] EN_DM_IDLE  = 2'b00;
    localparam logic [1:0] EN_DM_STORE = 2'b10;
    localparam logic [1:0] EN_DM_LOAD  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        RESP  = 2'd3
    } dm_state_t;

endpackage

`default_nettype wire

// File: rtl/dm_access_ctrl.sv
// ============================================================================
// dm_access_ctrl : splits 16/32-bit CPU load/store requests into 16-bit beats
// Revision: 1.0
// ============================================================================
`default_nettype none

module dm_access_ctrl
    import dm_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic                 req_size,
    input  logic [DM_ADDR_W-1:0] req_addr,
    input  logic [31:0]          req_wdata,
    output logic                 rsp_valid,
    output logic [31:0]          rsp_rdata,
    output logic [1:0]           en_dm,
    output logic [DM_ADDR_W-1:0] addr,
    output logic [DM_BEAT_W-1:0] store_in,
    input  logic [DM_BEAT_W-1:0] load_in
);

    dm_state_t              state_q,     state_d;
    logic                   we_q,        we_d;
    logic                   size_q,      size_d;
    logic [DM_ADDR_W-1:0]   areq_q,      areq_d;
    logic [DM_BEAT_W-1:0]   wlo_q,       wlo_d;
    logic [DM_BEAT_W-1:0]   rhi_q,       rhi_d;
    logic [1:0]             en_dm_q,     en_dm_d;
    logic [DM_ADDR_W-1:0]   addr_q,      addr_d;
    logic [DM_BEAT_W-1:0]   store_in_q,  store_in_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [31:0]            rsp_rdata_q, rsp_rdata_d;
    logic [1:0]             cmd;

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign en_dm     = en_dm_q;
    assign addr      = addr_q;
    assign store_in  = store_in_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            size_q      <= 1'b0;
            areq_q      <= '0;
            wlo_q       <= '0;
            rhi_q       <= '0;
            en_dm_q     <= EN_DM_IDLE;
            addr_q      <= '0;
            store_in_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            size_q      <= size_d;
            areq_q      <= areq_d;
            wlo_q       <= wlo_d;
            rhi_q       <= rhi_d;
            en_dm_q     <= en_dm_d;
            addr_q      <= addr_d;
            store_in_q  <= store_in_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Outputs are registered, so each state computes what the memory sees in
    // the following cycle; load data is sampled at the edge ending each beat.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        size_d      = size_q;
        areq_d      = areq_q;
        wlo_d       = wlo_q;
        rhi_d       = rhi_q;
        en_dm_d     = EN_DM_IDLE;
        addr_d      = addr_q;
        store_in_d  = '0;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        cmd         = we_q ? EN_DM_STORE : EN_DM_LOAD;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = BEAT0;
                    we_d    = req_we;
                    size_d  = req_size;
                    areq_d  = req_addr;
                    wlo_d   = req_wdata[15:0];
                    en_dm_d = req_we ? EN_DM_STORE : EN_DM_LOAD;
                    addr_d  = req_addr;
                    if (req_we) begin
                        store_in_d = req_size ? req_wdata[31:16] : req_wdata[15:0];
                    end
                end
            end
            BEAT0: begin
                if (size_q) begin
                    state_d    = BEAT1;
                    rhi_d      = load_in;
                    en_dm_d    = cmd;
                    // word index wraps inside [15:8]; the upper byte is untouched
                    addr_d     = {areq_q[23:16], areq_q[15:8] + 8'd1, areq_q[7:0]};
                    store_in_d = we_q ? wlo_q : '0;
                end else begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = we_q ? 32'h0 : {16'h0, load_in};
                end
            end
            BEAT1: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = we_q ? 32'h0 : {rhi_q, load_in};
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire
